// File: rtl/pipa_ctr_sequencer.sv
// pipa_ctr_sequencer: samples NCHAN plus/minus PIPA pulse-line pairs on the
// pipsam strobe and keeps a signed, saturating net pending count per channel.
// It then issues one PINC/MINC request at a time to the counter priority chain,
// using round-robin arbitration and a req/ack handshake.
// Optional build macro: PIPA_FAIL_DETECT_EN enables the both-active and
// repeated-idle PIPA fail detection. Without it, pipa_fail is tied low.
module pipa_ctr_sequencer #(
    parameter int NCHAN       = 3,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CH_W        = $clog2(NCHAN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCHAN-1:0] pipp_n,
    input  logic [NCHAN-1:0] pipm_n,
    input  logic             pipsam,
    input  logic             ctr_ack,
    input  logic             clr_flags,
    output logic             ctr_req,
    output logic [CH_W-1:0]  ctr_chan,
    output logic             ctr_minus,
    output logic [NCHAN-1:0] pend_ovf,
    output logic [NCHAN-1:0] pipa_fail
);

    // The sum needs two extra bits so that +MAX+1 and -MAX-1 stay representable
    // before clamping.
    localparam int SUM_W = CNT_W + 2;
    localparam logic signed [SUM_W-1:0] POS_MAX = SUM_W'((1 << (CNT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] NEG_MAX = -POS_MAX;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                              state_q, state_d;
    logic [SYNC_STAGES-1:0][NCHAN-1:0]   plusSync_q, minusSync_q;
    logic [NCHAN-1:0][CNT_W-1:0]         pend_q, pend_d;
    logic [CH_W-1:0]                     chan_q, chan_d;
    logic                                minus_q, minus_d;
    logic [CH_W-1:0]                     rrPtr_q, rrPtr_d;
    logic [NCHAN-1:0]                    pendOvf_q, pendOvf_d, ovfSet;
    logic [NCHAN-1:0]                    sp, sm, deltaPos, deltaNeg;
    logic                                ackFire;
    logic                                found;
    logic [CH_W-1:0]                     pick;

    assign sp      = plusSync_q[SYNC_STAGES-1];
    assign sm      = minusSync_q[SYNC_STAGES-1];
    assign ackFire = (state_q == REQ) && ctr_ack;

    // Active-low, asynchronous pulse lines are inverted into a shift-register synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plusSync_q  <= '0;
            minusSync_q <= '0;
        end else begin
            plusSync_q  <= {plusSync_q[SYNC_STAGES-2:0], ~pipp_n};
            minusSync_q <= {minusSync_q[SYNC_STAGES-2:0], ~pipm_n};
        end
    end

    // A sample contributes +1 or -1 only when exactly one of the two lines is active.
    always_comb begin
        deltaPos = '0;
        deltaNeg = '0;
        if (pipsam) begin
            deltaPos = sp & ~sm;
            deltaNeg = sm & ~sp;
        end
    end

    // Per-channel pending update: sample delta minus the completed request's
    // committed direction, clamped symmetrically to +/-MAX.
    always_comb begin
        logic signed [CNT_W-1:0] pendCur;
        logic signed [SUM_W-1:0] sum;
        pend_d  = pend_q;
        ovfSet  = '0;
        pendCur = '0;
        sum     = '0;
        for (int c = 0; c < NCHAN; c++) begin
            pendCur = pend_q[c];
            sum     = SUM_W'(pendCur);
            if (deltaPos[c]) sum = sum + SUM_W'(1);
            if (deltaNeg[c]) sum = sum - SUM_W'(1);
            if (ackFire && (chan_q == CH_W'(c))) begin
                if (minus_q) sum = sum + SUM_W'(1);
                else         sum = sum - SUM_W'(1);
            end
            if (sum > POS_MAX) begin
                pend_d[c] = POS_MAX[CNT_W-1:0];
                ovfSet[c] = 1'b1;
            end else if (sum < NEG_MAX) begin
                pend_d[c] = NEG_MAX[CNT_W-1:0];
                ovfSet[c] = 1'b1;
            end else begin
                pend_d[c] = sum[CNT_W-1:0];
            end
        end
    end

    // Round-robin search for the first nonzero channel, starting at rrPtr_q.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NCHAN; i++) begin
            idx = int'(rrPtr_q) + i;
            if (idx >= NCHAN) idx = idx - NCHAN;
            if (!found && (pend_q[idx] != '0)) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
    end

    // Sequencer next-state: commit channel and direction in IDLE, hold them through REQ.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        minus_d = minus_q;
        rrPtr_d = rrPtr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    chan_d  = pick;
                    minus_d = pend_q[pick][CNT_W-1];
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ctr_ack) begin
                    state_d = IDLE;
                    rrPtr_d = (chan_q == CH_W'(NCHAN - 1)) ? '0 : chan_q + CH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky overflow flags; a coincident set beats clr_flags.
    always_comb begin
        pendOvf_d = (clr_flags ? '0 : pendOvf_q) | ovfSet;
    end

    // State, pending counts, arbitration pointer and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            chan_q    <= '0;
            minus_q   <= 1'b0;
            rrPtr_q   <= '0;
            pendOvf_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            chan_q    <= chan_d;
            minus_q   <= minus_d;
            rrPtr_q   <= rrPtr_d;
            pendOvf_q <= pendOvf_d;
        end
    end

    assign ctr_req   = (state_q == REQ);
    assign ctr_chan  = chan_q;
    assign ctr_minus = minus_q;
    assign pend_ovf  = pendOvf_q;

`ifdef PIPA_FAIL_DETECT_EN
    logic [NCHAN-1:0] idleHist_q, idleHist_d, failSet;
    logic [NCHAN-1:0] pipaFail_q, pipaFail_d;

    // Both lines active, or two idle samples in a row, mark the PIPA as failed.
    // Any sample with at least one line active breaks an idle run.
    always_comb begin
        idleHist_d = idleHist_q;
        failSet    = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (pipsam) begin
                if (sp[c] && sm[c]) begin
                    failSet[c]    = 1'b1;
                    idleHist_d[c] = 1'b0;
                end else if (!sp[c] && !sm[c]) begin
                    failSet[c]    = idleHist_q[c];
                    idleHist_d[c] = 1'b1;
                end else begin
                    idleHist_d[c] = 1'b0;
                end
            end
        end
        pipaFail_d = (clr_flags ? '0 : pipaFail_q) | failSet;
    end

    // Idle-history and sticky fail registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idleHist_q <= '0;
            pipaFail_q <= '0;
        end else begin
            idleHist_q <= idleHist_d;
            pipaFail_q <= pipaFail_d;
        end
    end

    assign pipa_fail = pipaFail_q;
`else
    assign pipa_fail = '0;
`endif

endmodule
